// File: rtl/fetch_unpacker_pkg.sv
// Shared frontend types for the fetch unpacker: slot state, stride and branch-predict pack.
package fetch_unpacker_pkg;

    localparam int unsigned XLEN_MAX   = 64;
    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned BTYPE_W    = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SLOT0 = 2'd1,
        ST_SLOT1 = 2'd2
    } fu_state_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN_MAX-1:0] target;
        logic [BTYPE_W-1:0]  branch_type;
        logic                select;
        logic                taken;
    } bp_pack_t;

    // Slot 1 is dead when slot 0 is predicted taken.
    function automatic logic slot1_live(input logic valids_1, input bp_pack_t bp);
        return valids_1 & ~(bp.valid & bp.taken & ~bp.select);
    endfunction

endpackage

// File: rtl/fetch_unpacker.sv
// Splits two-slot fetch packets into a single-instruction stream, one per out handshake.
module fetch_unpacker #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned INST_BYTES = fetch_unpacker_pkg::INST_BYTES
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic            io_in_bits_valids_0,
    input  logic            io_in_bits_valids_1,
    input  logic [XLEN-1:0] io_in_bits_pc,
    input  logic [31:0]     io_in_bits_insts_0,
    input  logic [31:0]     io_in_bits_insts_1,
    input  logic            io_in_bits_bp_valid,
    input  logic [XLEN-1:0] io_in_bits_bp_target,
    input  logic [3:0]      io_in_bits_bp_branch_type,
    input  logic            io_in_bits_bp_select,
    input  logic            io_in_bits_bp_taken,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_out_bits_pc,
    output logic [31:0]     io_out_bits_inst,
    output logic            io_out_bits_bp_valid,
    output logic [XLEN-1:0] io_out_bits_bp_target,
    output logic [3:0]      io_out_bits_bp_branch_type,
    output logic            io_out_bits_bp_taken,
    input  logic            io_i_flush
);
    import fetch_unpacker_pkg::*;

    fu_state_e         r_state;
    fu_state_e         w_state_nxt;
    fu_state_e         w_in_state;
    logic [XLEN-1:0]   r_pc;
    logic [INST_W-1:0] r_inst_0;
    logic [INST_W-1:0] r_inst_1;
    logic              r_valids_1;
    bp_pack_t          r_bp;
    bp_pack_t          w_in_bp;
    logic              w_pkt_s1_live;
    logic              w_last_slot;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_slot_idx;

    assign w_in_bp = '{
        valid:       io_in_bits_bp_valid,
        target:      XLEN_MAX'(io_in_bits_bp_target),
        branch_type: io_in_bits_bp_branch_type,
        select:      io_in_bits_bp_select,
        taken:       io_in_bits_bp_taken
    };

    assign w_in_state = io_in_bits_valids_0                           ? ST_SLOT0 :
                        slot1_live(io_in_bits_valids_1, w_in_bp)      ? ST_SLOT1 : ST_EMPTY;
    assign w_pkt_s1_live = slot1_live(r_valids_1, r_bp);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshakes and next state; flush overrides everything else.
    always_comb begin
        w_state_nxt  = r_state;
        w_last_slot  = 1'b0;
        io_out_valid = 1'b0;
        io_in_ready  = 1'b0;
        w_out_fire   = 1'b0;
        w_in_fire    = 1'b0;

        w_last_slot  = (r_state == ST_SLOT1) || ((r_state == ST_SLOT0) && !w_pkt_s1_live);
        io_out_valid = (r_state != ST_EMPTY) && !io_i_flush;
        w_out_fire   = io_out_valid && io_out_ready;
        io_in_ready  = !io_i_flush && ((r_state == ST_EMPTY) || (w_out_fire && w_last_slot));
        w_in_fire    = io_in_valid && io_in_ready;

        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) w_state_nxt = w_in_state;
            end
            ST_SLOT0: begin
                if (w_out_fire) begin
                    if (w_pkt_s1_live)  w_state_nxt = ST_SLOT1;
                    else if (w_in_fire) w_state_nxt = w_in_state;
                    else                w_state_nxt = ST_EMPTY;
                end
            end
            ST_SLOT1: begin
                if (w_out_fire) w_state_nxt = w_in_fire ? w_in_state : ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase

        if (io_i_flush) w_state_nxt = ST_EMPTY;
    end

    // Packet register; slot-0 valid is implied by the state it produces.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc       <= '0;
            r_inst_0   <= '0;
            r_inst_1   <= '0;
            r_valids_1 <= 1'b0;
            r_bp       <= '0;
        end else if (w_in_fire) begin
            r_pc       <= io_in_bits_pc;
            r_inst_0   <= io_in_bits_insts_0;
            r_inst_1   <= io_in_bits_insts_1;
            r_valids_1 <= io_in_bits_valids_1;
            r_bp       <= w_in_bp;
        end
    end

    assign w_slot_idx = (r_state == ST_SLOT1);

    always_comb begin
        io_out_bits_pc             = r_pc;
        io_out_bits_inst           = r_inst_0;
        io_out_bits_bp_valid       = r_bp.valid & (r_bp.select == w_slot_idx);
        io_out_bits_bp_taken       = r_bp.taken & (r_bp.select == w_slot_idx);
        io_out_bits_bp_target      = XLEN'(r_bp.target);
        io_out_bits_bp_branch_type = r_bp.branch_type;
        if (w_slot_idx) begin
            io_out_bits_pc   = r_pc + XLEN'(INST_BYTES);
            io_out_bits_inst = r_inst_1;
        end
    end

endmodule

// File: tb/tb_fetch_unpacker.sv
// Randomized and directed bench for fetch_unpacker against a queue-based emission model.
module tb_fetch_unpacker;

    localparam int unsigned XLEN = 64;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            io_in_valid;
    logic            io_in_ready;
    logic            io_in_bits_valids_0;
    logic            io_in_bits_valids_1;
    logic [XLEN-1:0] io_in_bits_pc;
    logic [31:0]     io_in_bits_insts_0;
    logic [31:0]     io_in_bits_insts_1;
    logic            io_in_bits_bp_valid;
    logic [XLEN-1:0] io_in_bits_bp_target;
    logic [3:0]      io_in_bits_bp_branch_type;
    logic            io_in_bits_bp_select;
    logic            io_in_bits_bp_taken;
    logic            io_out_valid;
    logic            io_out_ready;
    logic [XLEN-1:0] io_out_bits_pc;
    logic [31:0]     io_out_bits_inst;
    logic            io_out_bits_bp_valid;
    logic [XLEN-1:0] io_out_bits_bp_target;
    logic [3:0]      io_out_bits_bp_branch_type;
    logic            io_out_bits_bp_taken;
    logic            io_i_flush;

    always #5 clock = ~clock;

    fetch_unpacker #(.XLEN(XLEN), .INST_BYTES(4)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_in_valid                (io_in_valid),
        .io_in_ready                (io_in_ready),
        .io_in_bits_valids_0        (io_in_bits_valids_0),
        .io_in_bits_valids_1        (io_in_bits_valids_1),
        .io_in_bits_pc              (io_in_bits_pc),
        .io_in_bits_insts_0         (io_in_bits_insts_0),
        .io_in_bits_insts_1         (io_in_bits_insts_1),
        .io_in_bits_bp_valid        (io_in_bits_bp_valid),
        .io_in_bits_bp_target       (io_in_bits_bp_target),
        .io_in_bits_bp_branch_type  (io_in_bits_bp_branch_type),
        .io_in_bits_bp_select       (io_in_bits_bp_select),
        .io_in_bits_bp_taken        (io_in_bits_bp_taken),
        .io_out_valid               (io_out_valid),
        .io_out_ready               (io_out_ready),
        .io_out_bits_pc             (io_out_bits_pc),
        .io_out_bits_inst           (io_out_bits_inst),
        .io_out_bits_bp_valid       (io_out_bits_bp_valid),
        .io_out_bits_bp_target      (io_out_bits_bp_target),
        .io_out_bits_bp_branch_type (io_out_bits_bp_branch_type),
        .io_out_bits_bp_taken       (io_out_bits_bp_taken),
        .io_i_flush                 (io_i_flush)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        bpv;
        logic        bpt;
        logic [63:0] tgt;
        logic [3:0]  bt;
    } emit_t;

    emit_t       q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic v0, input logic v1, input logic [63:0] pc,
                         input logic [31:0] i0, input logic [31:0] i1, input logic bpv,
                         input logic [63:0] tgt, input logic [3:0] bt, input logic sel,
                         input logic tk);
        io_in_valid               = vld;
        io_in_bits_valids_0       = v0;
        io_in_bits_valids_1       = v1;
        io_in_bits_pc             = pc;
        io_in_bits_insts_0        = i0;
        io_in_bits_insts_1        = i1;
        io_in_bits_bp_valid       = bpv;
        io_in_bits_bp_target      = tgt;
        io_in_bits_bp_branch_type = bt;
        io_in_bits_bp_select      = sel;
        io_in_bits_bp_taken       = tk;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 32'h0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic drive_rand();
        drive(1'(($urandom % 10) < 7), 1'($urandom), 1'($urandom), {$urandom, $urandom},
              $urandom, $urandom, 1'($urandom), {$urandom, $urandom}, 4'($urandom),
              1'($urandom), 1'($urandom));
    endtask

    // Model: an accepted packet contributes its live slots, in order, to the emission queue.
    task automatic accept_packet();
        emit_t e;
        logic  kill1;
        kill1 = io_in_bits_bp_valid && io_in_bits_bp_taken && (io_in_bits_bp_select == 1'b0);
        if (io_in_bits_valids_0) begin
            e.pc   = io_in_bits_pc;
            e.inst = io_in_bits_insts_0;
            e.bpv  = io_in_bits_bp_valid && (io_in_bits_bp_select == 1'b0);
            e.bpt  = io_in_bits_bp_taken && (io_in_bits_bp_select == 1'b0);
            e.tgt  = io_in_bits_bp_target;
            e.bt   = io_in_bits_bp_branch_type;
            q.push_back(e);
        end
        if (io_in_bits_valids_1 && !kill1) begin
            e.pc   = io_in_bits_pc + 64'd4;
            e.inst = io_in_bits_insts_1;
            e.bpv  = io_in_bits_bp_valid && (io_in_bits_bp_select == 1'b1);
            e.bpt  = io_in_bits_bp_taken && (io_in_bits_bp_select == 1'b1);
            e.tgt  = io_in_bits_bp_target;
            e.bt   = io_in_bits_bp_branch_type;
            q.push_back(e);
        end
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic step();
        logic  exp_vld;
        logic  exp_rdy;
        emit_t e;
        #1;
        exp_vld = (q.size() != 0) && !io_i_flush;
        exp_rdy = !io_i_flush && ((q.size() == 0) || (io_out_ready && (q.size() == 1)));
        check("out_valid", 64'(io_out_valid), 64'(exp_vld));
        check("in_ready", 64'(io_in_ready), 64'(exp_rdy));
        if (exp_vld) begin
            e = q[0];
            check("out_pc", io_out_bits_pc, e.pc);
            check("out_inst", 64'(io_out_bits_inst), 64'(e.inst));
            check("out_bp_valid", 64'(io_out_bits_bp_valid), 64'(e.bpv));
            check("out_bp_taken", 64'(io_out_bits_bp_taken), 64'(e.bpt));
            check("out_bp_target", io_out_bits_bp_target, e.tgt);
            check("out_bp_btype", 64'(io_out_bits_bp_branch_type), 64'(e.bt));
        end
        if (io_i_flush) begin
            q.delete();
        end else begin
            if (exp_vld && io_out_ready) void'(q.pop_front());
            if (exp_rdy && io_in_valid) accept_packet();
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [63:0] held_pc;
    logic [31:0] held_inst;

    initial begin
        drive_idle();
        io_out_ready = 1'b0;
        io_i_flush   = 1'b0;

        #12;
        check("rst_out_valid", 64'(io_out_valid), 64'h0);
        check("rst_in_ready", 64'(io_in_ready), 64'h1);
        check("rst_pc", io_out_bits_pc, 64'h0);
        check("rst_inst", 64'(io_out_bits_inst), 64'h0);
        check("rst_bp_valid", 64'(io_out_bits_bp_valid), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        io_out_ready = 1'b1;

        // Both slots valid: two emissions, ready only with the second.
        drive(1'b1, 1'b1, 1'b1, 64'h8000_0000, 32'hAAAA_0000, 32'hBBBB_1111,
              1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
        step();
        drive_idle();
        #1;
        check("d26_pc0", io_out_bits_pc, 64'h8000_0000);
        check("d26_inst0", 64'(io_out_bits_inst), 64'hAAAA_0000);
        check("d26_rdy0", 64'(io_in_ready), 64'h0);
        step();
        #1;
        check("d26_pc1", io_out_bits_pc, 64'h8000_0004);
        check("d26_inst1", 64'(io_out_bits_inst), 64'hBBBB_1111);
        check("d26_rdy1", 64'(io_in_ready), 64'h1);
        step();
        step();

        // Slot 1 only.
        drive(1'b1, 1'b0, 1'b1, 64'h0000_1000, 32'h1, 32'hCAFE_0001, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
        step();
        drive_idle();
        #1;
        check("d27_pc", io_out_bits_pc, 64'h0000_1004);
        check("d27_inst", 64'(io_out_bits_inst), 64'hCAFE_0001);
        step();
        #1;
        check("d27_done", 64'(io_out_valid), 64'h0);
        step();

        // Slot 0 predicted taken truncates the packet.
        drive(1'b1, 1'b1, 1'b1, 64'h0000_2000, 32'hD00D_0000, 32'hD00D_1111,
              1'b1, 64'h3000, 4'h5, 1'b0, 1'b1);
        step();
        drive_idle();
        #1;
        check("d28_bpv", 64'(io_out_bits_bp_valid), 64'h1);
        check("d28_bpt", 64'(io_out_bits_bp_taken), 64'h1);
        check("d28_tgt", io_out_bits_bp_target, 64'h3000);
        step();
        #1;
        check("d28_single", 64'(io_out_valid), 64'h0);
        step();

        // PC increment wraps modulo 2^XLEN.
        drive(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h5, 32'h6, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
        step();
        drive_idle();
        step();
        step();

        // Continuous supply, out_ready high: no output bubbles.
        drive(1'b1, 1'b1, 1'($urandom), {$urandom, $urandom}, $urandom, $urandom,
              1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 1'($urandom), {$urandom, $urandom}, $urandom, $urandom,
                  1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
            #1;
            check("d29_stream", 64'(io_out_valid), 64'h1);
            step();
        end
        drive_idle();
        step();
        step();
        step();

        // Stall for three cycles: outputs hold.
        drive(1'b1, 1'b1, 1'b1, 64'h0000_4000, 32'h4444_0000, 32'h4444_1111,
              1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
        step();
        drive_idle();
        io_out_ready = 1'b0;
        #1;
        held_pc   = io_out_bits_pc;
        held_inst = io_out_bits_inst;
        step();
        for (int k = 0; k < 2; k++) begin
            #1;
            check("d29_hold_pc", io_out_bits_pc, held_pc);
            check("d29_hold_inst", 64'(io_out_bits_inst), 64'(held_inst));
            step();
        end
        io_out_ready = 1'b1;
        step();
        step();
        step();

        // Flush in SLOT0 with an offered packet.
        drive(1'b1, 1'b1, 1'b1, 64'h0000_5000, 32'h5, 32'h6, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 64'h0000_6000, 32'h7, 32'h8, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
        io_i_flush = 1'b1;
        #1;
        check("d30_flush_valid", 64'(io_out_valid), 64'h0);
        check("d30_flush_ready", 64'(io_in_ready), 64'h0);
        step();
        io_i_flush = 1'b0;
        drive_idle();
        #1;
        check("d30_after_flush", 64'(io_out_valid), 64'h0);
        step();

        // Reset asserted while in SLOT1.
        drive(1'b1, 1'b1, 1'b1, 64'h0000_7000, 32'h9, 32'hA, 1'b1, 64'h77, 4'h3, 1'b1, 1'b1);
        step();
        drive_idle();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("d30_rst_valid", 64'(io_out_valid), 64'h0);
        check("d30_rst_ready", 64'(io_in_ready), 64'h1);
        check("d30_rst_pc", io_out_bits_pc, 64'h0);
        check("d30_rst_bpv", 64'(io_out_bits_bp_valid), 64'h0);
        q.delete();
        @(negedge clock);
        reset = 1'b1;
        step();
        step();

        // Randomized traffic with stalls and occasional flushes.
        for (int k = 0; k < 3000; k++) begin
            drive_rand();
            io_out_ready = 1'(($urandom % 4) != 0);
            io_i_flush   = 1'(($urandom % 20) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unpacker.md
FETCH_UNPACKER -- requirements
Module: fetch_unpacker

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the PC and branch-target width.
REQ-002 The block SHALL have parameter INST_BYTES, default 4, giving the PC stride between slot 0 and slot 1.
REQ-003 The block SHALL have ports clock (input, 1) as the single clock and reset (input, 1); reset is asynchronous and active-low.
REQ-004 The block SHALL have input-side ports: io_in_valid (in, 1), io_in_ready (out, 1), io_in_bits_valids_0 and io_in_bits_valids_1 (in, 1 each), io_in_bits_pc (in, XLEN), io_in_bits_insts_0 and io_in_bits_insts_1 (in, 32 each).
REQ-005 The block SHALL have branch-predict input ports io_in_bits_bp_valid (in, 1), io_in_bits_bp_target (in, XLEN), io_in_bits_bp_branch_type (in, 4), io_in_bits_bp_select (in, 1; slot index) and io_in_bits_bp_taken (in, 1).
REQ-006 The block SHALL have output-side ports: io_out_valid (out, 1), io_out_ready (in, 1), io_out_bits_pc (out, XLEN), io_out_bits_inst (out, 32).
REQ-007 The block SHALL have branch-predict output ports io_out_bits_bp_valid (out, 1), io_out_bits_bp_target (out, XLEN), io_out_bits_bp_branch_type (out, 4) and io_out_bits_bp_taken (out, 1).
REQ-008 The block SHALL have port io_i_flush (in, 1): pipeline redirect that discards held state.

Function
REQ-009 The block SHALL dequeue two-slot fetch packets and emit one instruction per out handshake, in slot order.
REQ-010 The block SHALL hold a state register with states EMPTY, SLOT0 and SLOT1, plus a packet register capturing all in_bits on an in handshake.
REQ-011 On an in handshake, state SHALL become SLOT0 if valids_0 is set, otherwise SLOT1 if the effective slot-1 valid is set, otherwise EMPTY (packet dropped).
REQ-012 The effective slot-1 valid SHALL be valids_1 AND NOT (bp_valid AND bp_taken AND bp_select==0), so that the predicted-taken slot 0 truncates the packet.
REQ-013 io_out_valid SHALL be (state != EMPTY) AND NOT io_i_flush.
REQ-014 io_in_ready SHALL be NOT io_i_flush AND (state==EMPTY OR (out handshake AND current slot is the last live slot)).
REQ-015 In SLOT0, io_out_bits_pc SHALL be the packet pc and inst SHALL be insts_0; in SLOT1, pc SHALL be pc+INST_BYTES (modulo 2^XLEN) and inst SHALL be insts_1.
REQ-016 io_out_bits_bp_valid and io_out_bits_bp_taken SHALL be the packet values ANDed with (bp_select == current slot index); target and branch_type SHALL pass through unmasked.
REQ-017 An out handshake in SLOT0 SHALL move state to SLOT1 if effective slot-1 is live; otherwise the state SHALL follow REQ-011 for a simultaneous in handshake, or go to EMPTY.
REQ-018 An out handshake in SLOT1 SHALL load a simultaneous in packet per REQ-011, or go to EMPTY, giving zero-bubble back-to-back streaming.
REQ-019 Without an out handshake, state and packet register SHALL hold, and outputs SHALL be stable while out_valid is high.
REQ-020 Latency from in handshake to io_out_valid SHALL be exactly 1 cycle.
REQ-021 io_i_flush SHALL force state to EMPTY at the next edge, overriding any simultaneous in or out handshake; no instruction is emitted during the flush cycle.

Reset
REQ-022 Asserting reset low SHALL immediately clear state to EMPTY and the packet register to 0, giving io_out_valid=0 and io_in_ready=1 (flush low) and all out_bits=0.
REQ-023 Reset asserted mid-packet SHALL discard the remaining slot, with no emission after release until a new in handshake.

Structure
REQ-024 The state enum, INST_BYTES and the branch-predict pack type (valid/target/branch_type/select/taken) SHALL live in the shared frontend package.
REQ-025 The block SHALL be a single module; slot selection is small enough that no sub-module is required.

Verification
REQ-026 Packet pc=0x8000_0000 with both slots valid and out_ready=1 SHALL produce outputs pc=0x8000_0000/insts_0, then pc=0x8000_0004/insts_1, with in_ready high only in the second emit cycle.
REQ-027 valids_0=0, valids_1=1 SHALL produce a single emission at pc+4 with insts_1.
REQ-028 bp_valid=1, taken=1, select=0 with both slots valid SHALL produce only slot 0, with out bp_valid=1 and taken=1.
REQ-029 Continuous in packets with out_ready=1 SHALL emit one instruction every cycle with no bubbles; holding out_ready=0 for 3 cycles SHALL keep outputs stable.
REQ-030 io_i_flush in SLOT0 together with in_valid=1 SHALL give out_valid=0 that cycle, state EMPTY next cycle, and the in packet not accepted; reset low in SLOT1 SHALL give out_valid=0 immediately.
